// File: rtl/led_pkg.sv
// Purpose : shared constants, FSM state encoding and a width helper for the LED sequencer.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package led_pkg;

   localparam int LED_BITS = 8;

   typedef enum logic {
      RUN   = 1'b0,
      BLANK = 1'b1
   } state_t;

   // Smallest r with 2**r >= value; used for counter and index widths.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose : synchronise a raw button, debounce it, emit a one-cycle pulse on each debounced press.
// Latency : rise pulses 2 sync cycles + 2**DEBOUNCE_LOG2 stable cycles after the raw edge.
// Backpressure : none; the pulse is a strobe and is not held.
// Ports : clk, rst_n (async active-low), btn (raw, async), rise (one-cycle press strobe).
module btn_debounce
   import led_pkg::*;
#(
   parameter int DEBOUNCE_LOG2 = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic                     sync_q1;
   logic                     sync_q2;
   logic                     level;
   logic [DEBOUNCE_LOG2-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         level   <= 1'b0;
         cnt     <= '0;
         rise    <= 1'b0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
         rise    <= 1'b0;
         if (sync_q2 != level) begin
            // Last of 2**DEBOUNCE_LOG2 consecutive differing cycles: accept the new level.
            if (&cnt) begin
               level <= sync_q2;
               cnt   <= '0;
               rise  <= sync_q2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            // Any bounce back to the current level restarts the qualification window.
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Purpose : share the 8-LED bank between NUM_SRC pattern sources with a blanked mode switch.
// Latency : led follows the active source with 1 cycle; mode changes only on BLANK->RUN.
// Backpressure : none; step_en/tick are strobes, button presses during BLANK are dropped.
// Ports : clk, rst_n, btn_in (raw button), auto_en (auto-cycle level), src_pattern (source i
//         at [i*8 +: 8]); step_en (advance strobe to active source), led, mode, tick.
module led_pattern_sequencer
   import led_pkg::*;
#(
   parameter int LOG2DELAY     = 22,
   parameter int DEBOUNCE_LOG2 = 16,
   parameter int NUM_SRC       = 4,
   parameter int BLANK_TICKS   = 2,
   parameter int AUTO_TICKS    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          btn_in,
   input  logic                          auto_en,
   input  logic [NUM_SRC*LED_BITS-1:0]   src_pattern,
   output logic [NUM_SRC-1:0]            step_en,
   output logic [LED_BITS-1:0]           led,
   output logic [clog2(NUM_SRC)-1:0]     mode,
   output logic                          tick
);

   localparam int MODE_W  = clog2(NUM_SRC);
   localparam int AUTO_W  = clog2(AUTO_TICKS + 1);
   localparam int BLANK_W = clog2(BLANK_TICKS + 1);

   localparam logic [AUTO_W-1:0]  AUTO_LAST  = AUTO_W'(AUTO_TICKS - 1);
   localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_TICKS - 1);
   localparam logic [MODE_W-1:0]  MODE_LAST  = MODE_W'(NUM_SRC - 1);

   logic [LOG2DELAY-1:0] presc_cnt;
   logic                 next_req;

   state_t               state;
   state_t               state_nxt;
   logic [MODE_W-1:0]    mode_nxt;
   logic [LED_BITS-1:0]  led_nxt;
   logic [AUTO_W-1:0]    auto_cnt;
   logic [AUTO_W-1:0]    auto_nxt;
   logic [BLANK_W-1:0]   blank_cnt;
   logic [BLANK_W-1:0]   blank_nxt;

   logic [LED_BITS-1:0]  pat_arr [NUM_SRC];
   logic [LED_BITS-1:0]  active_pat;
   logic                 auto_expire;

   // Free-running prescaler; tick is the all-ones cycle so the first one lands at 2**LOG2DELAY-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + 1'b1;
      end
   end

   assign tick = &presc_cnt;

   btn_debounce #(
      .DEBOUNCE_LOG2 (DEBOUNCE_LOG2)
   ) u_btn_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_in),
      .rise  (next_req)
   );

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_pat
      assign pat_arr[i] = src_pattern[i*LED_BITS +: LED_BITS];
   end

   assign active_pat  = pat_arr[mode];
   assign auto_expire = auto_en && tick && (auto_cnt == AUTO_LAST);

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode;
      led_nxt   = '0;
      auto_nxt  = auto_cnt;
      blank_nxt = blank_cnt;
      step_en   = '0;
      unique case (state)
         RUN: begin
            step_en[mode] = tick;
            led_nxt       = active_pat;
            if (auto_en && tick) begin
               auto_nxt = auto_cnt + 1'b1;
            end
            // Button and auto expiry together still make a single advance.
            if (next_req || auto_expire) begin
               state_nxt = BLANK;
               led_nxt   = '0;
               blank_nxt = '0;
               auto_nxt  = '0;
            end
         end
         BLANK: begin
            // next_req is deliberately ignored here: presses while blanked are not queued.
            if (tick) begin
               blank_nxt = blank_cnt + 1'b1;
               if (blank_cnt == BLANK_LAST) begin
                  state_nxt = RUN;
                  blank_nxt = '0;
                  mode_nxt  = (mode == MODE_LAST) ? '0 : mode + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // led_nxt stays 0 on the BLANK->RUN cycle, so the new source shows one cycle after mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         mode      <= '0;
         led       <= '0;
         auto_cnt  <= '0;
         blank_cnt <= '0;
      end else begin
         state     <= state_nxt;
         mode      <= mode_nxt;
         led       <= led_nxt;
         auto_cnt  <= auto_nxt;
         blank_cnt <= blank_nxt;
      end
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Purpose : directed bench for led_pattern_sequencer with a tick-driven scoreboard.
// Latency : n/a.
// Backpressure : n/a.
module tb_led_pattern_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_in;
   logic        auto_en;
   logic [31:0] src_pattern;
   logic [3:0]  step_en;
   logic [7:0]  led;
   logic [1:0]  mode;
   logic        tick;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] led;
      logic [3:0] step;
   } tick_exp_t;

   typedef struct {
      int         cyc;
      logic [1:0] mode;
      logic [7:0] led;
   } cyc_exp_t;

   tick_exp_t tq[$];
   cyc_exp_t  cq[$];
   tick_exp_t te;
   cyc_exp_t  ce;

   led_pattern_sequencer #(
      .LOG2DELAY     (3),
      .DEBOUNCE_LOG2 (2),
      .NUM_SRC       (4),
      .BLANK_TICKS   (2),
      .AUTO_TICKS    (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .auto_en     (auto_en),
      .src_pattern (src_pattern),
      .step_en     (step_en),
      .led         (led),
      .mode        (mode),
      .tick        (tick)
   );

   always #5 clk = ~clk;

   // Cycle index since the latest reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_tick(input logic [1:0] m, input logic [7:0] l, input logic [3:0] s);
      tq.push_back({m, l, s});
   endtask

   task automatic push_cyc(input int c, input logic [1:0] m, input logic [7:0] l);
      cyc_exp_t e;
      e.cyc = c;
      e.mode = m;
      e.led = l;
      cq.push_back(e);
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   // Monitor: checks every cycle away from the active edge, pops the scoreboard on each tick.
   always @(negedge clk) begin
      if (rst_n) begin
         vectors++;
         if ((tick !== ((cyc % 8) == 7)) || (!tick && step_en != 4'b0) || !$onehot0(step_en)) begin
            miscompares++;
            $display("FAIL cycle_invariant: cycle %0d tick=%b step_en=%b, expected tick=%b and step_en one-hot only on tick",
                     cyc, tick, step_en, ((cyc % 8) == 7));
         end
         if (tick) begin
            if (tq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_tick: cycle %0d mode=%0d led=%h step_en=%b, no expectation queued",
                        cyc, mode, led, step_en);
            end else begin
               te = tq.pop_front();
               vectors++;
               if ({mode, led, step_en} !== {te.mode, te.led, te.step}) begin
                  miscompares++;
                  $display("FAIL tick_state: cycle %0d got mode=%0d led=%h step_en=%b, expected mode=%0d led=%h step_en=%b",
                           cyc, mode, led, step_en, te.mode, te.led, te.step);
               end
            end
         end
         if (cq.size() != 0 && cq[0].cyc == cyc) begin
            ce = cq.pop_front();
            vectors++;
            if ({mode, led} !== {ce.mode, ce.led}) begin
               miscompares++;
               $display("FAIL cycle_state: cycle %0d got mode=%0d led=%h, expected mode=%0d led=%h",
                        cyc, mode, led, ce.mode, ce.led);
            end
         end
      end
   end

   initial begin
      btn_in      = 1'b0;
      auto_en     = 1'b0;
      src_pattern = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      repeat (3) @(negedge clk);
      chk("reset_mode", mode, 0);
      chk("reset_led", led, 0);
      chk("reset_step_en", step_en, 0);
      chk("reset_tick", tick, 0);

      // Reset release and free-running ticks in mode 0.
      push_cyc(0, 2'd0, 8'h00);
      push_cyc(1, 2'd0, 8'hA1);
      repeat (3) push_tick(2'd0, 8'hA1, 4'b0001);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Long press: next_req at cycle 30, blank over ticks 3-4, mode 1 from cycle 40.
      wait_cyc(24);
      repeat (2) push_tick(2'd0, 8'h00, 4'b0000);
      repeat (2) push_tick(2'd1, 8'hB2, 4'b0010);
      push_cyc(40, 2'd1, 8'h00);
      push_cyc(41, 2'd1, 8'hB2);
      btn_in = 1'b1;
      wait_cyc(44);
      btn_in = 1'b0;

      // Bounce every 2 cycles: never stable for 4 cycles, so nothing changes.
      wait_cyc(56);
      repeat (5) push_tick(2'd1, 8'hB2, 4'b0010);
      for (int i = 0; i < 15; i++) begin
         wait_cyc(56 + 2 * i);
         btn_in = ((i % 2) == 0);
      end
      wait_cyc(86);
      btn_in = 1'b0;

      // Two more presses to reach mode 3.
      wait_cyc(96);
      repeat (2) push_tick(2'd1, 8'h00, 4'b0000);
      push_tick(2'd2, 8'hC3, 4'b0100);
      repeat (2) push_tick(2'd2, 8'h00, 4'b0000);
      push_tick(2'd3, 8'hD4, 4'b1000);
      btn_in = 1'b1;
      wait_cyc(106);
      btn_in = 1'b0;
      wait_cyc(120);
      btn_in = 1'b1;
      wait_cyc(130);
      btn_in = 1'b0;

      // Auto-cycle from mode 3: expiry on tick 21, wrap to mode 0 at cycle 192.
      wait_cyc(144);
      repeat (4) push_tick(2'd3, 8'hD4, 4'b1000);
      repeat (2) push_tick(2'd3, 8'h00, 4'b0000);
      repeat (3) push_tick(2'd0, 8'hA1, 4'b0001);
      push_cyc(192, 2'd0, 8'h00);
      push_cyc(193, 2'd0, 8'hA1);
      auto_en = 1'b1;

      // Press lands on the auto-expiry tick (cycle 223); second press during BLANK is dropped.
      wait_cyc(216);
      push_tick(2'd0, 8'hA1, 4'b0001);
      repeat (2) push_tick(2'd0, 8'h00, 4'b0000);
      repeat (2) push_tick(2'd1, 8'hB2, 4'b0010);
      wait_cyc(217);
      btn_in = 1'b1;
      wait_cyc(221);
      btn_in = 1'b0;
      wait_cyc(228);
      btn_in = 1'b1;
      wait_cyc(232);
      btn_in = 1'b0;

      // Enter BLANK again, then reset asynchronously in the middle of it.
      wait_cyc(256);
      push_tick(2'd1, 8'h00, 4'b0000);
      btn_in = 1'b1;
      wait_cyc(260);
      btn_in = 1'b0;
      wait_cyc(266);
      chk("queue_drain_pre_reset", tq.size(), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midblank_reset_mode", mode, 0);
      chk("midblank_reset_led", led, 0);
      chk("midblank_reset_step_en", step_en, 0);
      chk("midblank_reset_tick", tick, 0);

      repeat (2) @(negedge clk);
      auto_en = 1'b0;
      push_cyc(0, 2'd0, 8'h00);
      push_cyc(1, 2'd0, 8'hA1);
      push_tick(2'd0, 8'hA1, 4'b0001);
      @(posedge clk);
      #1 rst_n = 1'b1;

      wait_cyc(9);
      @(posedge clk);
      #1;
      chk("tick_queue_empty", tq.size(), 0);
      chk("cycle_queue_empty", cq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Controller that shares the 8-LED bank between NUM_SRC pattern generators (gray counter, LFSR, etc.). It derives the slow step tick, debounces the user button, and runs a mode FSM that selects the active source, gates its step enable, and blanks the LEDs between mode switches. It sits between the pattern generators and the LED pins at top level, replacing the raw combinational `sel` mux.

Parameters:
LOG2DELAY, 22, tick period is 2^LOG2DELAY clk cycles
DEBOUNCE_LOG2, 16, button must be stable for 2^DEBOUNCE_LOG2 cycles
NUM_SRC, 4, number of pattern sources (2..8)
BLANK_TICKS, 2, ticks of LEDs-off between modes (>=1)
AUTO_TICKS, 64, ticks per mode when auto-cycling (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_in  in  1  raw button, active-high, asynchronous to clk
auto_en  in  1  enable automatic mode cycling (synchronous level)
src_pattern  in  NUM_SRC*8  source i pattern at bits [i*8 +: 8]
step_en  out  NUM_SRC  one-cycle advance strobe to the active source only
led  out  8  registered LED drive, led[7] = LED1
mode  out  clog2(NUM_SRC)  active source index
tick  out  1  one-cycle pulse every 2^LOG2DELAY cycles

Behaviour:
- Reset (async assert, sync release): state RUN, mode 0, led 0, step_en 0, tick 0; all counters 0; debounced level 0.
- Prescaler: free-running LOG2DELAY-bit counter; tick=1 for the cycle in which the counter is all-ones; wraps to 0. First tick at cycle 2^LOG2DELAY-1 after reset release.
- Button: 2-FF synchroniser, then debouncer: the debounced level changes only after the synchronised input differs from it for 2^DEBOUNCE_LOG2 consecutive cycles; any bounce restarts the count. A debounced 0->1 edge produces a one-cycle next_req. Releasing produces nothing.
- FSM states: RUN, BLANK.
  - RUN: led <= src_pattern[mode*8 +: 8] every cycle (1-cycle latency). step_en[mode] = tick, other bits 0. auto_cnt increments on tick when auto_en=1; held when auto_en=0.
  - RUN -> BLANK when next_req=1, or when auto_en=1 and tick=1 and auto_cnt==AUTO_TICKS-1. Button and auto expiry in the same cycle produce one advance. On entry: led <= 0, blank_cnt <= 0, auto_cnt <= 0.
  - BLANK: led held 0, step_en all 0. blank_cnt increments on tick. When tick=1 and blank_cnt==BLANK_TICKS-1: mode <= (mode==NUM_SRC-1) ? 0 : mode+1, go to RUN. next_req in BLANK is dropped and not queued.
- mode changes only at BLANK->RUN. The first RUN cycle still shows led=0; the new source appears on the next cycle.
- Deasserting auto_en mid-count freezes auto_cnt. Reasserting it resumes from the frozen value.
- Reset mid-BLANK returns to RUN with mode 0 and led 0 immediately.
- step_en is always one-hot or zero and is never asserted outside a tick cycle.

Decomposition:
- Shared package led_pkg: LED_BITS=8; FSM state encoding (RUN=1'b0, BLANK=1'b1); clog2 function.
- One sub-module, btn_debounce (synchroniser, debounce counter, rising-edge pulse), parameterised by DEBOUNCE_LOG2.
- The prescaler and FSM stay in led_pattern_sequencer.

Test Plan:
Bench parameters: LOG2DELAY=3, DEBOUNCE_LOG2=2, NUM_SRC=4, BLANK_TICKS=2, AUTO_TICKS=4; src_pattern = {8'hD4, 8'hC3, 8'hB2, 8'hA1}.
1. Reset and tick: release rst_n, auto_en=0 -> tick pulses at cycles 7, 15, 23; led=8'hA1 from cycle 1; step_en=4'b0001 only on tick cycles; mode=0.
2. Button advance: hold btn_in=1 for 20 cycles -> one next_req; led=0 for 2 ticks; then mode=1, led=8'hB2, step_en=4'b0010 on ticks; releasing gives no second advance.
3. Bounce rejection: toggle btn_in every 2 cycles for 30 cycles, then hold 0 -> no next_req, mode unchanged, led unchanged.
4. Auto-cycle and wrap: auto_en=1 from mode 3 -> after 4 ticks BLANK, after 2 more ticks mode=0, led=8'hA1; step_en never asserted during BLANK.
5. Simultaneous events: debounced edge lands on the auto-expiry tick -> exactly one advance (mode+1). A second press during BLANK -> ignored; mode advances only once.
6. Reset mid-BLANK: assert rst_n=0 asynchronously during BLANK -> led=0, mode=0, step_en=0 within the same cycle; after release, RUN resumes with led=8'hA1 one cycle later.
